timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_bus_if.sv | 19 +
 rtl/timer_counter.sv | 106 ++++++++++
 tb/tb_timer_counter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_bus_if.sv
// Processor-side bus for the timer: word select, write strobe and data in,
// combinational read data and interrupt request out.
interface timer_bus_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr, we, wdata,
    input  rdata, irq
  );

  modport slave (
    input  addr, we, wdata,
    output rdata, irq
  );
endinterface

// File: rtl/timer_counter.sv
// Programmable down-counting timer with CTRL/PRESET/COUNT registers, one-shot
// (mode 0) or auto-reload (mode 1) operation and a maskable interrupt.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  timer_bus_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'd1;

  state_e      state_q;
  ctrl_t       ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_flag_q;

  logic ctrl_we;
  logic preset_we;

  assign ctrl_we   = bus.we && (bus.addr == ADDR_CTRL);
  assign preset_we = bus.we && (bus.addr == ADDR_PRESET);

  // NOTE: every register has a reset value here; the block is small and the
  // bus must read all zeros the instant reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ctrl_q.en) state_q <= LOAD;
        end
        LOAD: begin
          count_q <= preset_q;
          state_q <= CNT;
        end
        CNT: begin
          if (!ctrl_q.en) begin
            state_q <= IDLE;
          end else if (count_q != 32'd0) begin
            count_q <= count_q - 32'd1;
          end else begin
            state_q    <= INT;
            irq_flag_q <= 1'b1;
          end
        end
        INT: begin
          if (ctrl_q.mode == MODE_RELOAD) begin
            state_q    <= LOAD;
            irq_flag_q <= 1'b0;
          end else begin
            ctrl_q.en <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // NOTE: non-blocking assignments made later in the block win, so bus
      // writes placed after the FSM override its Enable clear and irq_flag set.
      if (ctrl_we) begin
        ctrl_q     <= ctrl_t'(bus.wdata[3:0]);
        irq_flag_q <= 1'b0;
      end
      if (preset_we) begin
        preset_q   <= bus.wdata;
        irq_flag_q <= 1'b0;
      end
    end
  end

  always_comb begin
    // NOTE: default assigned first so no addr value leaves rdata unassigned,
    // which would otherwise infer a latch.
    bus.rdata = '0;
    case (bus.addr)
      ADDR_CTRL:   bus.rdata = {28'd0, ctrl_q};
      ADDR_PRESET: bus.rdata = preset_q;
      ADDR_COUNT:  bus.rdata = count_q;
      default:     bus.rdata = '0;
    endcase
  end

  assign bus.irq = irq_flag_q & ctrl_q.im;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: a vector table for the one-shot
// timeline, directed corner sequences, and random traffic against a model.
module tb_timer_counter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  timer_bus_if bus ();

  timer_counter dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // Reference model: spec-level timer state, advanced one edge at a time.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CNT = 2, PH_INT = 3;

  typedef struct {
    int          phase;
    bit          en;
    bit [1:0]    mode;
    bit          im;
    logic [31:0] preset;
    logic [31:0] count;
    bit          flag;
  } model_t;

  model_t mdl;

  function automatic model_t model_reset();
    model_t m;
    m.phase = PH_IDLE; m.en = 0; m.mode = 0; m.im = 0;
    m.preset = 0; m.count = 0; m.flag = 0;
    return m;
  endfunction

  function automatic model_t model_next(model_t m, bit w, logic [1:0] a, logic [31:0] d);
    model_t n = m;
    if (m.phase == PH_IDLE) begin
      if (m.en) n.phase = PH_LOAD;
    end else if (m.phase == PH_LOAD) begin
      n.count = m.preset;
      n.phase = PH_CNT;
    end else if (m.phase == PH_CNT) begin
      if (!m.en)             n.phase = PH_IDLE;
      else if (m.count > 0)  n.count = m.count - 1;
      else begin n.phase = PH_INT; n.flag = 1; end
    end else begin
      if (m.mode == 2'd1) begin n.phase = PH_LOAD; n.flag = 0; end
      else begin n.en = 0; n.phase = PH_IDLE; end
    end
    if (w && a == 2'd0) begin
      n.en = d[0]; n.mode = d[2:1]; n.im = d[3]; n.flag = 0;
    end
    if (w && a == 2'd1) begin
      n.preset = d; n.flag = 0;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock edge with the given bus inputs; leaves time at edge + 1.
  task automatic tick(input bit w, input logic [1:0] a, input logic [31:0] d);
    bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1;
    mdl = model_next(mdl, w, a, d);
    bus.we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.rdata;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mdl = model_reset();
  endtask

  typedef struct {
    bit          w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp_count;
    logic        exp_irq;
    logic [31:0] exp_ctrl;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] v;
    checks = 0;
    failures = 0;
    bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'd0;
    rst_n = 1'b0;
    mdl = model_reset();

    // One-shot timeline: PRESET=5, CTRL=0x9 at edge t (entry 1), then a
    // PRESET write clears the held interrupt.
    vecs[0]  = '{1'b1, 2'd1, 32'd5, 32'd0, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 2'd0, 32'd9, 32'd0, 1'b0, 32'd9};
    vecs[2]  = '{1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd9};
    vecs[3]  = '{1'b0, 2'd0, 32'd0, 32'd5, 1'b0, 32'd9};
    vecs[4]  = '{1'b0, 2'd0, 32'd0, 32'd4, 1'b0, 32'd9};
    vecs[5]  = '{1'b0, 2'd0, 32'd0, 32'd3, 1'b0, 32'd9};
    vecs[6]  = '{1'b0, 2'd0, 32'd0, 32'd2, 1'b0, 32'd9};
    vecs[7]  = '{1'b0, 2'd0, 32'd0, 32'd1, 1'b0, 32'd9};
    vecs[8]  = '{1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 32'd9};
    vecs[9]  = '{1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 32'd9};
    vecs[10] = '{1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 32'd8};
    vecs[11] = '{1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 32'd8};
    vecs[12] = '{1'b1, 2'd1, 32'd7, 32'd0, 1'b0, 32'd8};

    // Values while reset is held.
    #3;
    rd(2'd0, v); check("reset_ctrl", v, 32'd0);
    rd(2'd1, v); check("reset_preset", v, 32'd0);
    rd(2'd2, v); check("reset_count", v, 32'd0);
    check("reset_irq", {31'd0, bus.irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      tick(vecs[i].w, vecs[i].a, vecs[i].d);
      rd(2'd2, v); check($sformatf("oneshot_count[%0d]", i), v, vecs[i].exp_count);
      check($sformatf("oneshot_irq[%0d]", i), {31'd0, bus.irq}, {31'd0, vecs[i].exp_irq});
      rd(2'd0, v); check($sformatf("oneshot_ctrl[%0d]", i), v, vecs[i].exp_ctrl);
    end

    // Mode 1 auto-reload: PRESET=3 gives a one-cycle pulse every 6 cycles.
    do_reset();
    tick(1'b1, 2'd1, 32'd3);
    tick(1'b1, 2'd0, 32'hB);
    for (int k = 1; k < 20; k++) begin
      logic [31:0] exp_cnt;
      int p;
      tick(1'b0, 2'd0, 32'd0);
      p = (k - 2) % 6;
      exp_cnt = (k < 2 || p > 2) ? 32'd0 : 32'(3 - p);
      rd(2'd2, v); check($sformatf("reload_count[t+%0d]", k), v, exp_cnt);
      check($sformatf("reload_irq[t+%0d]", k), {31'd0, bus.irq},
            (k >= 6 && (k - 6) % 6 == 0) ? 32'd1 : 32'd0);
    end

    // IM=0 masks the flag; a later CTRL write clears the flag itself.
    do_reset();
    tick(1'b1, 2'd1, 32'd2);
    tick(1'b1, 2'd0, 32'h1);
    for (int k = 1; k < 8; k++) begin
      tick(1'b0, 2'd0, 32'd0);
      check($sformatf("masked_irq[t+%0d]", k), {31'd0, bus.irq}, 32'd0);
    end
    rd(2'd0, v); check("masked_enable_cleared", v, 32'd0);
    tick(1'b1, 2'd0, 32'h8);
    check("unmask_after_clear_irq", {31'd0, bus.irq}, 32'd0);

    // CTRL rewritten on the INT edge keeps Enable and restarts via LOAD.
    do_reset();
    tick(1'b1, 2'd1, 32'd2);
    tick(1'b1, 2'd0, 32'h9);
    idle(5);
    check("race_irq_at_int", {31'd0, bus.irq}, 32'd1);
    tick(1'b1, 2'd0, 32'h9);
    rd(2'd0, v); check("race_ctrl_kept", v, 32'd9);
    check("race_irq_cleared", {31'd0, bus.irq}, 32'd0);
    idle(2);
    rd(2'd2, v); check("race_reloaded_count", v, 32'd2);

    // PRESET=0, addr 3 reads zero, writes to COUNT/addr 3 ignored.
    do_reset();
    tick(1'b1, 2'd1, 32'd0);
    tick(1'b1, 2'd0, 32'h9);
    idle(2);
    check("zero_irq_before_int", {31'd0, bus.irq}, 32'd0);
    idle(1);
    check("zero_irq_at_int", {31'd0, bus.irq}, 32'd1);
    rd(2'd3, v); check("addr3_reads_zero", v, 32'd0);
    idle(1);
    tick(1'b1, 2'd1, 32'd10);
    tick(1'b1, 2'd0, 32'h1);
    idle(2);
    rd(2'd2, v); check("ro_count_loaded", v, 32'd10);
    tick(1'b1, 2'd2, 32'h1234);
    rd(2'd2, v); check("ro_count_write_ignored", v, 32'd9);
    tick(1'b1, 2'd3, 32'hFFFF_FFFF);
    rd(2'd2, v); check("ro_addr3_write_count", v, 32'd8);
    rd(2'd0, v); check("ro_addr3_write_ctrl", v, 32'd1);
    rd(2'd1, v); check("ro_addr3_write_preset", v, 32'd10);
    rd(2'd3, v); check("addr3_reads_zero_busy", v, 32'd0);

    // Reset dropped between edges at COUNT=4.
    do_reset();
    tick(1'b1, 2'd1, 32'd10);
    tick(1'b1, 2'd0, 32'h9);
    idle(8);
    rd(2'd2, v); check("abort_count_before", v, 32'd4);
    #1;
    rst_n = 1'b0;
    rd(2'd2, v); check("abort_count", v, 32'd0);
    rd(2'd0, v); check("abort_ctrl", v, 32'd0);
    rd(2'd1, v); check("abort_preset", v, 32'd0);
    check("abort_irq", {31'd0, bus.irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mdl = model_reset();
    idle(6);
    rd(2'd2, v); check("post_reset_count", v, 32'd0);
    rd(2'd0, v); check("post_reset_ctrl", v, 32'd0);
    check("post_reset_irq", {31'd0, bus.irq}, 32'd0);

    // Random bus traffic against the reference model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      bit          w;
      logic [1:0]  a;
      logic [31:0] d;
      w = ($urandom_range(0, 5) == 0);
      a = 2'($urandom_range(0, 3));
      d = (a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
      tick(w, a, d);
      rd(2'd2, v); check("rand_count", v, mdl.count);
      rd(2'd1, v); check("rand_preset", v, mdl.preset);
      rd(2'd0, v); check("rand_ctrl", v, {28'd0, mdl.im, mdl.mode, mdl.en});
      check("rand_irq", {31'd0, bus.irq}, {31'd0, mdl.flag & mdl.im});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
